// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream_rr
// Purpose  : N-to-1 valid/ready stream mux, fixed-select or round-robin,
//            with a single registered output stage.
// Revision : 1.0
// ============================================================================
module mux_stream_rr #(
  parameter  int bus_width = 8,
  parameter  int channels  = 4,
  localparam int sel_w     = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [channels*bus_width-1:0] in_data,
  input  logic [channels-1:0]           in_valid,
  output logic [channels-1:0]           in_ready,
  input  logic                          mode,
  input  logic [sel_w-1:0]              sel,
  output logic [bus_width-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [sel_w-1:0]              out_ch
);

  localparam logic [sel_w-1:0] c_rr_init = sel_w'(channels - 1);

  logic [bus_width-1:0] r_out_data;
  logic                 r_out_valid;
  logic [sel_w-1:0]     r_out_ch;
  logic [sel_w-1:0]     r_rr_last;

  logic                 w_load_en;
  logic                 w_fix_valid;
  logic                 w_rr_valid;
  logic [sel_w-1:0]     w_rr_grant;
  logic [sel_w-1:0]     w_grant;
  logic                 w_grant_valid;
  logic                 w_xfer_in;
  logic [bus_width-1:0] w_grant_data;

  // Holding reset low on in_ready keeps upstream from losing words to reset.
  assign w_load_en = !rst && (!r_out_valid || out_ready);

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    w_fix_valid = 1'b0;
    for (int k = 0; k < channels; k++) begin
      if (sel == sel_w'(k)) w_fix_valid = in_valid[k];
    end
  end

  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_grant = '0;
    for (int i = 1; i <= channels; i++) begin
      if (!w_rr_valid && in_valid[(int'(r_rr_last) + i) % channels]) begin
        w_rr_valid = 1'b1;
        w_rr_grant = sel_w'((int'(r_rr_last) + i) % channels);
      end
    end
  end

  assign w_grant       = mode ? w_rr_grant : sel;
  assign w_grant_valid = mode ? w_rr_valid : w_fix_valid;
  assign w_xfer_in     = w_load_en && w_grant_valid;

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < channels; k++) begin
      if (w_grant == sel_w'(k)) w_grant_data = in_data[k*bus_width +: bus_width];
    end
  end

  genvar g;
  generate
    for (g = 0; g < channels; g++) begin : g_ready
      assign in_ready[g] = w_xfer_in && (w_grant == sel_w'(g));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_last   <= c_rr_init;
    end else if (w_xfer_in) begin
      r_out_data  <= w_grant_data;
      r_out_ch    <= w_grant;
      r_out_valid <= 1'b1;
      if (mode) r_rr_last <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

endmodule
`default_nettype wire
